sail_stdout_arbiter: RTL and testbench
======================================

SAIL_STDOUT_ARBITER -- requirements
Module: sail_stdout_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning the number of requesters (2..16).
REQ-002 SHALL have parameter NL_CHAR, default 8'h0A, meaning the byte appended for endline messages.
REQ-003 SHALL have one clock and an asynchronous, active-high reset, named per codebase convention as clk and rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 req_valid  input  NREQ  per-requester byte valid.
REQ-007 req_data  input  NREQ*8  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-008 req_last  input  NREQ  marks the final byte of a message.
REQ-009 req_endline  input  NREQ  qualified with req_last; requests NL_CHAR after the final byte.
REQ-010 req_ready  output  NREQ  per-requester byte accepted.
REQ-011 out_valid  output  1  stdout byte valid.
REQ-012 out_data  output  8  stdout byte.
REQ-013 out_ready  input  1  downstream sink accepts the byte.
REQ-014 out_src  output  $clog2(NREQ)  index of the requester owning the current message.
REQ-015 busy  output  1  high while not in IDLE.
REQ-016 msg_count  output  16  count of completed messages.

Function
REQ-017 SHALL be an FSM with states IDLE, PASS and NEWLINE.
REQ-018 IDLE: when any req_valid bit is high, SHALL register grant as the first requester with req_valid high, searching from last_grant+1 upward with modulo-NREQ wrap, and go to PASS next cycle.
REQ-019 IDLE: SHALL drive out_valid=0 and req_ready=0.
REQ-020 PASS: SHALL drive out_valid=req_valid[grant], out_data=req_data[grant] and req_ready[grant]=out_ready combinationally; all other req_ready bits SHALL be 0.
REQ-021 A byte transfer SHALL occur only when req_valid[grant] and out_ready are both high in the same cycle.
REQ-022 PASS: a transfer with req_last[grant]=0 SHALL stay in PASS; the grant SHALL be held for the whole message.
REQ-023 PASS: a transfer with req_last=1 and req_endline=0 SHALL go to IDLE, increment msg_count and set last_grant=grant.
REQ-024 PASS: a transfer with req_last=1 and req_endline=1 SHALL go to NEWLINE and set last_grant=grant.
REQ-025 NEWLINE: SHALL drive out_valid=1, out_data=NL_CHAR and all req_ready=0; on out_ready SHALL go to IDLE and increment msg_count.
REQ-026 If the granted requester deasserts valid mid-message, SHALL stay in PASS with out_valid=0; no other requester may interleave.
REQ-027 SHALL not pass a byte through in the IDLE arbitration cycle; minimum cost per message is 1 arbitration cycle plus 1 cycle per byte.
REQ-028 msg_count SHALL wrap from 16'hFFFF to 16'h0000.
REQ-029 out_src SHALL equal grant in PASS and NEWLINE, and 0 in IDLE.
REQ-030 req_last and req_endline SHALL be ignored except on a transfer.
REQ-031 busy SHALL be 1 in PASS and NEWLINE and 0 in IDLE.

Reset
REQ-032 On rst SHALL asynchronously set state=IDLE, grant=0, last_grant=NREQ-1, msg_count=0, out_valid=0, req_ready=0, out_src=0 and busy=0.
REQ-033 Reset asserted mid-message SHALL abandon the message with no trailing NL_CHAR and no msg_count increment.
REQ-034 The first arbitration after reset SHALL favour requester 0.

Verification
REQ-035 Bench SHALL cover: req0 sends "hi" (0x68, 0x69 with last, endline=0), out_ready=1 -> out bytes 0x68, 0x69 on consecutive cycles after 1 idle cycle; msg_count=1; no 0x0A.
REQ-036 Bench SHALL cover: req2 sends "ok" with endline=1 -> out sequence 0x6F, 0x6B, 0x0A with out_src=2; msg_count increments only after 0x0A is accepted.
REQ-037 Bench SHALL cover: all 4 requesters hold valid continuously with 1-byte messages -> grant order 0, 1, 2, 3, 0 and no requester starves.
REQ-038 Bench SHALL cover: req1 mid-message drops valid for 3 cycles while req3 is valid -> out_valid=0 for 3 cycles, req_ready[3]=0, then req1 resumes.
REQ-039 Bench SHALL cover: out_ready held low for 5 cycles in PASS and in NEWLINE -> out_data stable, no req_ready pulse, no byte loss or duplication.
REQ-040 Bench SHALL cover: rst pulsed in PASS, then msg_count preloaded to 16'hFFFF via 65535 messages plus one more -> after rst outputs match REQ-032; msg_count wraps to 0.

Source files
------------

// File: rtl/sail_stdout_arbiter.sv
// Purpose: merges per-requester byte streams onto one stdout byte stream, one whole message at a time.
// Latency: one arbitration cycle per message, then bytes pass combinationally (1 cycle per byte), plus one cycle for an optional NL_CHAR.
// Backpressure: out_ready is routed straight to the granted requester's req_ready; a stalled sink or a silent grantee holds the grant.
//
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   req_valid/req_data  per-requester byte stream (requester i uses req_data[8i+7:8i])
//   req_last            final byte of a message
//   req_endline         with req_last: emit NL_CHAR after the final byte
//   req_ready           per-requester byte accepted (only the grantee can see a 1)
//   out_valid/out_data  stdout byte stream toward the sink, out_ready from the sink
//   out_src             requester owning the current message (0 while idle)
//   busy                high while a message is in flight
//   msg_count           completed messages, wraps at 16 bits
module sail_stdout_arbiter #(
    parameter int          NREQ    = 4,
    parameter logic [7:0]  NL_CHAR = 8'h0A,
    localparam int         SRC_W   = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*8-1:0]   req_data,
    input  logic [NREQ-1:0]     req_last,
    input  logic [NREQ-1:0]     req_endline,
    output logic [NREQ-1:0]     req_ready,
    output logic                out_valid,
    output logic [7:0]          out_data,
    input  logic                out_ready,
    output logic [SRC_W-1:0]    out_src,
    output logic                busy,
    output logic [15:0]         msg_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PASS    = 2'd1,
        NEWLINE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [SRC_W-1:0]    grant_q, grant_d;
    logic [SRC_W-1:0]    last_grant_q, last_grant_d;
    logic [15:0]         msg_count_q;
    logic                msg_done;

    logic                arb_hit;
    logic [SRC_W-1:0]    arb_idx;
    logic                xfer;

    // Round-robin search starting just after the previous owner. Starting
    // at offset 1 and ending at offset NREQ puts the previous owner last,
    // so a requester that keeps its valid high cannot lock out the others.
    always_comb begin
        int cand;
        arb_hit = 1'b0;
        arb_idx = '0;
        cand    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last_grant_q) + k) % NREQ;
            if (!arb_hit && req_valid[cand]) begin
                arb_hit = 1'b1;
                arb_idx = cand[SRC_W-1:0];
            end
        end
    end

    // A byte moves only when the grantee offers one and the sink takes it.
    assign xfer = (state_q == PASS) && req_valid[grant_q] && out_ready;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        msg_done     = 1'b0;
        out_valid    = 1'b0;
        out_data     = 8'h00;
        req_ready    = '0;
        out_src      = '0;
        busy         = 1'b0;

        case (state_q)
            IDLE: begin
                // Arbitration cycle only; nothing passes through here.
                if (arb_hit) begin
                    grant_d = arb_idx;
                    state_d = PASS;
                end
            end

            PASS: begin
                busy               = 1'b1;
                out_src            = grant_q;
                out_valid          = req_valid[grant_q];
                out_data           = req_data[8*int'(grant_q) +: 8];
                req_ready[grant_q] = out_ready;
                // last/endline are only meaningful alongside an accepted byte.
                if (xfer && req_last[grant_q]) begin
                    last_grant_d = grant_q;
                    if (req_endline[grant_q]) begin
                        state_d = NEWLINE;
                    end else begin
                        state_d  = IDLE;
                        msg_done = 1'b1;
                    end
                end
            end

            NEWLINE: begin
                busy      = 1'b1;
                out_src   = grant_q;
                out_valid = 1'b1;
                out_data  = NL_CHAR;
                // The message only counts once its trailing newline is taken.
                if (out_ready) begin
                    state_d  = IDLE;
                    msg_done = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            // Previous owner = NREQ-1 makes the first search begin at 0.
            last_grant_q <= SRC_W'(NREQ - 1);
            msg_count_q  <= 16'h0000;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            if (msg_done) begin
                msg_count_q <= msg_count_q + 16'd1;
            end
        end
    end

    assign msg_count = msg_count_q;

endmodule

// File: tb/tb_sail_stdout_arbiter.sv
module tb_sail_stdout_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  req_endline = '0;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready = 1'b0;
    logic [1:0]  out_src;
    logic        busy;
    logic [15:0] msg_count;

    int total = 0;
    int bad   = 0;

    logic [7:0] acc_q[$];

    sail_stdout_arbiter #(.NREQ(4), .NL_CHAR(8'h0A)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_endline(req_endline),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .out_src    (out_src),
        .busy       (busy),
        .msg_count  (msg_count)
    );

    always #5 clk = ~clk;

    // Record every byte the sink accepts, to catch loss or duplication.
    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) acc_q.push_back(out_data);
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rst_req_ready: got %b want 0000", req_ready); end
        total++; if (out_src !== 2'd0) begin bad++; $display("FAIL rst_out_src: got %0d want 0", out_src); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (msg_count !== 16'h0000) begin bad++; $display("FAIL rst_msg_count: got %h want 0000", msg_count); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_hi();
        acc_q.delete();
        @(negedge clk);
        req_valid = 4'b0001; req_data[7:0] = 8'h68; req_last = 4'b0000; out_ready = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL hi_idle: got valid=%b busy=%b want 0 0", out_valid, busy); end
        @(negedge clk); #1;
        total++; if (out_valid !== 1'b1 || out_data !== 8'h68 || req_ready !== 4'b0001 || out_src !== 2'd0)
            begin bad++; $display("FAIL hi_byte0: got v=%b d=%h rdy=%b src=%0d want 1 68 0001 0", out_valid, out_data, req_ready, out_src); end
        @(negedge clk);
        req_data[7:0] = 8'h69; req_last = 4'b0001;
        #1;
        total++; if (out_valid !== 1'b1 || out_data !== 8'h69 || req_ready !== 4'b0001)
            begin bad++; $display("FAIL hi_byte1: got v=%b d=%h rdy=%b want 1 69 0001", out_valid, out_data, req_ready); end
        @(negedge clk);
        req_valid = 4'b0000; req_last = 4'b0000;
        #1;
        total++; if (busy !== 1'b0 || out_valid !== 1'b0 || msg_count !== 16'd1)
            begin bad++; $display("FAIL hi_done: got busy=%b v=%b cnt=%0d want 0 0 1", busy, out_valid, msg_count); end
        total++; if (acc_q.size() !== 2 || acc_q[0] !== 8'h68 || acc_q[1] !== 8'h69)
            begin bad++; $display("FAIL hi_stream: got %0d bytes want 68 69 only", acc_q.size()); end
    endtask

    task automatic test_ok_endline();
        acc_q.delete();
        @(negedge clk);
        req_valid = 4'b0100; req_data[23:16] = 8'h6F; req_last = 4'b0000; req_endline = 4'b0000;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ok_idle: got busy=%b want 0", busy); end
        @(negedge clk); #1;
        total++; if (out_src !== 2'd2 || out_data !== 8'h6F || req_ready !== 4'b0100)
            begin bad++; $display("FAIL ok_byte0: got src=%0d d=%h rdy=%b want 2 6f 0100", out_src, out_data, req_ready); end
        @(negedge clk);
        req_data[23:16] = 8'h6B; req_last = 4'b0100; req_endline = 4'b0100;
        #1;
        total++; if (out_data !== 8'h6B || out_valid !== 1'b1) begin bad++; $display("FAIL ok_byte1: got d=%h v=%b want 6b 1", out_data, out_valid); end
        @(negedge clk);
        req_valid = 4'b0000; req_last = 4'b0000; req_endline = 4'b0000;
        #1;
        total++; if (out_valid !== 1'b1 || out_data !== 8'h0A || out_src !== 2'd2 || req_ready !== 4'b0000)
            begin bad++; $display("FAIL ok_newline: got v=%b d=%h src=%0d rdy=%b want 1 0a 2 0000", out_valid, out_data, out_src, req_ready); end
        total++; if (msg_count !== 16'd1) begin bad++; $display("FAIL ok_count_early: got %0d want 1", msg_count); end
        @(negedge clk); #1;
        total++; if (busy !== 1'b0 || msg_count !== 16'd2) begin bad++; $display("FAIL ok_done: got busy=%b cnt=%0d want 0 2", busy, msg_count); end
        total++; if (acc_q.size() !== 3 || acc_q[0] !== 8'h6F || acc_q[1] !== 8'h6B || acc_q[2] !== 8'h0A)
            begin bad++; $display("FAIL ok_stream: got %0d bytes want 6f 6b 0a", acc_q.size()); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_src [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        req_valid = 4'b1111; req_last = 4'b1111; req_endline = 4'b0000; out_ready = 1'b1;
        req_data = 32'h33323130;
        for (int m = 0; m < 5; m++) begin
            #1;
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL rr_idle%0d: got busy=%b want 0", m, busy); end
            @(negedge clk); #1;
            total++; if (out_src !== exp_src[m] || out_data !== (8'h30 + 8'(exp_src[m])) || req_ready !== (4'b0001 << exp_src[m]))
                begin bad++; $display("FAIL rr_grant%0d: got src=%0d d=%h rdy=%b want %0d", m, out_src, out_data, req_ready, exp_src[m]); end
            @(negedge clk);
        end
        req_valid = 4'b0000; req_last = 4'b0000;
        #1;
        total++; if (msg_count !== 16'd5) begin bad++; $display("FAIL rr_count: got %0d want 5", msg_count); end
    endtask

    task automatic test_stall();
        acc_q.delete();
        @(negedge clk);
        req_valid = 4'b0010; req_data[15:8] = 8'h41; req_last = 4'b0000;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL stall_idle: got busy=%b want 0", busy); end
        @(negedge clk); #1;
        total++; if (out_src !== 2'd1 || out_data !== 8'h41) begin bad++; $display("FAIL stall_byte0: got src=%0d d=%h want 1 41", out_src, out_data); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            req_valid = 4'b1000; req_data[31:24] = 8'h5A; req_last = 4'b1000;
            #1;
            total++; if (out_valid !== 1'b0 || req_ready[3] !== 1'b0 || out_src !== 2'd1 || busy !== 1'b1)
                begin bad++; $display("FAIL stall_gap%0d: got v=%b rdy=%b src=%0d busy=%b want 0 x0xx 1 1", c, out_valid, req_ready, out_src, busy); end
        end
        @(negedge clk);
        req_valid = 4'b1010; req_data[15:8] = 8'h42; req_last = 4'b1010;
        #1;
        total++; if (out_valid !== 1'b1 || out_data !== 8'h42 || out_src !== 2'd1 || req_ready !== 4'b0010)
            begin bad++; $display("FAIL stall_resume: got v=%b d=%h src=%0d rdy=%b want 1 42 1 0010", out_valid, out_data, out_src, req_ready); end
        @(negedge clk);
        req_valid = 4'b1000; req_last = 4'b1000;
        #1;
        total++; if (busy !== 1'b0 || msg_count !== 16'd6) begin bad++; $display("FAIL stall_done1: got busy=%b cnt=%0d want 0 6", busy, msg_count); end
        @(negedge clk); #1;
        total++; if (out_src !== 2'd3 || out_data !== 8'h5A) begin bad++; $display("FAIL stall_req3: got src=%0d d=%h want 3 5a", out_src, out_data); end
        @(negedge clk);
        req_valid = 4'b0000; req_last = 4'b0000;
        #1;
        total++; if (msg_count !== 16'd7) begin bad++; $display("FAIL stall_count: got %0d want 7", msg_count); end
        total++; if (acc_q.size() !== 3 || acc_q[0] !== 8'h41 || acc_q[1] !== 8'h42 || acc_q[2] !== 8'h5A)
            begin bad++; $display("FAIL stall_stream: got %0d bytes want 41 42 5a", acc_q.size()); end
    endtask

    task automatic test_backpressure();
        acc_q.delete();
        @(negedge clk);
        req_valid = 4'b0001; req_data[7:0] = 8'h41; req_last = 4'b0000; req_endline = 4'b0000; out_ready = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_idle: got busy=%b want 0", busy); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            total++; if (out_valid !== 1'b1 || out_data !== 8'h41 || req_ready !== 4'b0000)
                begin bad++; $display("FAIL bp_pass_hold%0d: got v=%b d=%h rdy=%b want 1 41 0000", c, out_valid, out_data, req_ready); end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0001 || out_data !== 8'h41) begin bad++; $display("FAIL bp_release: got rdy=%b d=%h want 0001 41", req_ready, out_data); end
        @(negedge clk);
        req_data[7:0] = 8'h42; req_last = 4'b0001; req_endline = 4'b0001;
        #1;
        total++; if (out_data !== 8'h42) begin bad++; $display("FAIL bp_byte1: got d=%h want 42", out_data); end
        @(negedge clk);
        req_valid = 4'b0000; req_last = 4'b0000; req_endline = 4'b0000; out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            total++; if (out_valid !== 1'b1 || out_data !== 8'h0A || req_ready !== 4'b0000 || busy !== 1'b1 || msg_count !== 16'd7)
                begin bad++; $display("FAIL bp_nl_hold%0d: got v=%b d=%h rdy=%b busy=%b cnt=%0d want 1 0a 0000 1 7", c, out_valid, out_data, req_ready, busy, msg_count); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        total++; if (out_data !== 8'h0A || out_valid !== 1'b1) begin bad++; $display("FAIL bp_nl_release: got v=%b d=%h want 1 0a", out_valid, out_data); end
        @(negedge clk); #1;
        total++; if (busy !== 1'b0 || msg_count !== 16'd8) begin bad++; $display("FAIL bp_done: got busy=%b cnt=%0d want 0 8", busy, msg_count); end
        total++; if (acc_q.size() !== 3 || acc_q[0] !== 8'h41 || acc_q[1] !== 8'h42 || acc_q[2] !== 8'h0A)
            begin bad++; $display("FAIL bp_stream: got %0d bytes want 41 42 0a", acc_q.size()); end
    endtask

    task automatic test_reset_and_wrap();
        acc_q.delete();
        @(negedge clk);
        req_valid = 4'b0100; req_data[23:16] = 8'h55; req_last = 4'b0000; req_endline = 4'b0000; out_ready = 1'b1;
        @(negedge clk); #1;
        total++; if (out_src !== 2'd2 || out_data !== 8'h55) begin bad++; $display("FAIL rm_pass: got src=%0d d=%h want 2 55", out_src, out_data); end
        @(negedge clk);
        req_data[23:16] = 8'h56; req_last = 4'b0100; req_endline = 4'b0100;
        #1; rst = 1'b1; #1;
        total++; if (out_valid !== 1'b0 || req_ready !== 4'b0000 || out_src !== 2'd0 || busy !== 1'b0 || msg_count !== 16'd0)
            begin bad++; $display("FAIL rm_async: got v=%b rdy=%b src=%0d busy=%b cnt=%0d want 0 0000 0 0 0", out_valid, req_ready, out_src, busy, msg_count); end
        @(negedge clk);
        rst = 1'b0;
        req_valid = 4'b0101; req_last = 4'b0101; req_endline = 4'b0000;
        req_data[7:0] = 8'h60; req_data[23:16] = 8'h62;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_idle: got busy=%b want 0", busy); end
        @(negedge clk); #1;
        total++; if (out_src !== 2'd0 || out_data !== 8'h60) begin bad++; $display("FAIL rm_first_grant: got src=%0d d=%h want 0 60", out_src, out_data); end
        total++; if (acc_q.size() !== 1 || acc_q[0] !== 8'h55) begin bad++; $display("FAIL rm_abandon: got %0d bytes want only 55", acc_q.size()); end
        req_valid = 4'b1111; req_last = 4'b1111;
        @(negedge clk);
        repeat (2 * 65534) @(negedge clk);
        #1;
        total++; if (msg_count !== 16'hFFFF) begin bad++; $display("FAIL wrap_preload: got %h want ffff", msg_count); end
        repeat (2) @(negedge clk);
        #1;
        total++; if (msg_count !== 16'h0000) begin bad++; $display("FAIL wrap_zero: got %h want 0000", msg_count); end
        req_valid = 4'b0000; req_last = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_hi();
        test_ok_endline();
        test_round_robin();
        test_stall();
        test_backpressure();
        test_reset_and_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
